// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory access controller: op encodings,
// FSM states, default memory size and small decode helpers.
package dm_pkg;

    typedef enum logic [2:0] {
        OP_LB  = 3'b000,
        OP_LBU = 3'b001,
        OP_LH  = 3'b010,
        OP_LHU = 3'b011,
        OP_LW  = 3'b100,
        OP_SB  = 3'b101,
        OP_SH  = 3'b110,
        OP_SW  = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    localparam logic [31:0] ADDR_LIMIT_DEFAULT = 32'h0000_1000;

    function automatic logic is_store(input logic [2:0] op);
        return op[2] & (op != OP_LW);
    endfunction

    function automatic logic misaligned(input logic [2:0] op, input logic [1:0] addr_lo);
        logic bad;
        case (op)
            OP_LH, OP_LHU, OP_SH: bad = addr_lo[0];
            OP_LW, OP_SW:         bad = |addr_lo;
            default:              bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dm_load_ext.sv
// Selects the addressed byte/half/word lane from a RAM word and applies
// sign or zero extension according to the load op.
module dm_load_ext
    import dm_pkg::*;
(
    input  logic [31:0] mem_rd,
    input  logic [2:0]  op,
    input  logic [1:0]  addr_lo,
    output logic [31:0] ext
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr_lo)
            2'd0:    byte_sel = mem_rd[7:0];
            2'd1:    byte_sel = mem_rd[15:8];
            2'd2:    byte_sel = mem_rd[23:16];
            default: byte_sel = mem_rd[31:24];
        endcase
        half_sel = addr_lo[1] ? mem_rd[31:16] : mem_rd[15:0];

        case (op)
            OP_LB:   ext = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  ext = {24'd0, byte_sel};
            OP_LH:   ext = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  ext = {16'd0, half_sel};
            default: ext = mem_rd;
        endcase
    end

endmodule

// File: rtl/dm_access_ctrl.sv
// Load/store access controller in front of the 4 KB data RAM: checks each
// request, drives the RAM port for one cycle and returns extended load data.
module dm_access_ctrl
    import dm_pkg::*;
#(
    parameter logic [31:0] ADDR_LIMIT = ADDR_LIMIT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic [2:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        adel,
    output logic        ades,
    output logic [9:0]  mem_a,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wd,
    output logic        mem_we,
    input  logic [31:0] mem_rd
);

    state_e      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [11:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;

    logic        access_err;
    logic [31:0] load_ext;
    logic        store_q;

    // The range check uses the full incoming address, so only the
    // in-memory offset needs to be kept after accept.
    assign access_err = misaligned(op, addr[1:0]) | (addr >= ADDR_LIMIT);
    assign store_q    = is_store(op_q);

    dm_load_ext u_load_ext (
        .mem_rd  (mem_rd),
        .op      (op_q),
        .addr_lo (addr_q[1:0]),
        .ext     (load_ext)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            op_q    <= 3'd0;
            addr_q  <= 12'd0;
            wdata_q <= 32'd0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    op_d    = op;
                    addr_d  = addr[11:0];
                    wdata_d = wdata;
                    err_d   = access_err;
                    state_d = access_err ? ST_RESP : ST_ACCESS;
                end
            end
            ST_ACCESS: state_d = store_q ? ST_RESP : ST_WAIT;
            ST_WAIT: begin
                rdata_d = load_ext;
                state_d = ST_RESP;
            end
            ST_RESP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // RAM strobes decode straight from the state flop so reset kills a write at once.
    always_comb begin
        mem_we = (state_q == ST_ACCESS) & store_q;
        mem_be = 4'b0000;
        mem_wd = wdata_q;
        case (op_q)
            OP_SB: mem_wd = {4{wdata_q[7:0]}};
            OP_SH: mem_wd = {2{wdata_q[15:0]}};
            default: mem_wd = wdata_q;
        endcase
        if (mem_we) begin
            case (op_q)
                OP_SB:   mem_be = 4'b0001 << addr_q[1:0];
                OP_SH:   mem_be = addr_q[1] ? 4'b1100 : 4'b0011;
                default: mem_be = 4'b1111;
            endcase
        end
    end

    assign mem_a = addr_q[11:2];
    assign busy  = (state_q != ST_IDLE);
    assign done  = (state_q == ST_RESP);
    assign adel  = done & err_q & ~store_q;
    assign ades  = done & err_q & store_q;
    assign rdata = rdata_q;

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Directed bench for dm_access_ctrl with a behavioural synchronous-read RAM.
module tb_dm_access_ctrl;

    logic        clk;
    logic        reset;
    logic        req;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] rdata;
    logic        adel;
    logic        ades;
    logic [9:0]  mem_a;
    logic [3:0]  mem_be;
    logic [31:0] mem_wd;
    logic        mem_we;
    logic [31:0] mem_rd;

    int checks;
    int failures;

    logic [31:0] ram [0:1023];

    dm_access_ctrl dut (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .op     (op),
        .addr   (addr),
        .wdata  (wdata),
        .busy   (busy),
        .done   (done),
        .rdata  (rdata),
        .adel   (adel),
        .ades   (ades),
        .mem_a  (mem_a),
        .mem_be (mem_be),
        .mem_wd (mem_wd),
        .mem_we (mem_we),
        .mem_rd (mem_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++)
                if (mem_be[i]) ram[mem_a][8*i +: 8] <= mem_wd[8*i +: 8];
        end
        mem_rd <= ram[mem_a];
    end

    // Issues one request (accept at the end of the current cycle) and watches until done.
    task automatic do_access(input logic [2:0] o, input logic [31:0] a, input logic [31:0] wd,
                             output int lat, output int we_cnt, output int be_cnt,
                             output logic [9:0] acc_a, output logic [3:0] acc_be,
                             output logic [31:0] acc_wd, output logic e_l, output logic e_s,
                             output logic busy_ok);
        @(negedge clk);
        req = 1'b1; op = o; addr = a; wdata = wd;
        lat = -1; we_cnt = 0; be_cnt = 0; acc_a = '0; acc_be = '0; acc_wd = '0;
        e_l = 1'b0; e_s = 1'b0; busy_ok = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (!busy) busy_ok = 1'b0;
            if (k == 1) acc_a = mem_a;
            if (mem_be != 4'b0000) be_cnt++;
            if (mem_we) begin
                we_cnt++;
                acc_be = mem_be;
                acc_wd = mem_wd;
            end
            if (done) begin
                lat = k;
                e_l = adel;
                e_s = ades;
                break;
            end
        end
        req = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; req = 1'b0; op = 3'd0; addr = '0; wdata = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, adel, ades, mem_we} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctrl got busy/done/adel/ades/we=%b required 00000",
                     {busy, done, adel, ades, mem_we});
        end
        checks++;
        if (rdata !== 32'd0 || mem_wd !== 32'd0) begin
            failures++;
            $display("FAIL reset_data got rdata=%h mem_wd=%h required 0/0", rdata, mem_wd);
        end
        checks++;
        if (mem_a !== 10'd0 || mem_be !== 4'd0) begin
            failures++;
            $display("FAIL reset_addr got mem_a=%h mem_be=%b required 0/0", mem_a, mem_be);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_release got busy=%b done=%b required 0/0", busy, done);
        end
    endtask

    task automatic test_store();
        int lat, wc, bc; logic [9:0] aa; logic [3:0] be; logic [31:0] wd; logic el, es, bo;
        do_access(3'b111, 32'h100, 32'hDEADBEEF, lat, wc, bc, aa, be, wd, el, es, bo);
        checks++;
        if (lat != 2 || wc != 1 || !bo) begin
            failures++;
            $display("FAIL sw_timing got lat=%0d we_cycles=%0d busy_ok=%b required 2/1/1", lat, wc, bo);
        end
        checks++;
        if (aa !== 10'h040 || be !== 4'b1111 || wd !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL sw_port got a=%h be=%b wd=%h required 040/1111/deadbeef", aa, be, wd);
        end
        checks++;
        if (el !== 1'b0 || es !== 1'b0) begin
            failures++;
            $display("FAIL sw_err got adel=%b ades=%b required 0/0", el, es);
        end
        do_access(3'b101, 32'h101, 32'h000000AB, lat, wc, bc, aa, be, wd, el, es, bo);
        checks++;
        if (lat != 2 || be !== 4'b0010 || wd !== 32'hABABABAB) begin
            failures++;
            $display("FAIL sb_port got lat=%0d be=%b wd=%h required 2/0010/abababab", lat, be, wd);
        end
        checks++;
        if (ram[10'h040] !== 32'hDEADABEF) begin
            failures++;
            $display("FAIL sb_ram got %h required deadabef", ram[10'h040]);
        end
        do_access(3'b110, 32'h102, 32'h00001234, lat, wc, bc, aa, be, wd, el, es, bo);
        checks++;
        if (lat != 2 || be !== 4'b1100 || wd !== 32'h12341234) begin
            failures++;
            $display("FAIL sh_port got lat=%0d be=%b wd=%h required 2/1100/12341234", lat, be, wd);
        end
        checks++;
        if (ram[10'h040] !== 32'h1234ABEF) begin
            failures++;
            $display("FAIL sh_ram got %h required 1234abef", ram[10'h040]);
        end
    endtask

    task automatic test_load();
        logic [2:0]  ops  [5] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100};
        logic [31:0] adrs [5] = '{32'h103, 32'h103, 32'h102, 32'h100, 32'h100};
        logic [31:0] exps [5] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD, 32'h0000BEEF, 32'hDEADBEEF};
        int lat, wc, bc; logic [9:0] aa; logic [3:0] be; logic [31:0] wd; logic el, es, bo;
        do_access(3'b111, 32'h100, 32'hDEADBEEF, lat, wc, bc, aa, be, wd, el, es, bo);
        for (int i = 0; i < 5; i++) begin
            do_access(ops[i], adrs[i], 32'h0, lat, wc, bc, aa, be, wd, el, es, bo);
            checks++;
            if (rdata !== exps[i] || lat != 3) begin
                failures++;
                $display("FAIL load_%0d got rdata=%h lat=%0d required %h/3", i, rdata, lat, exps[i]);
            end
            checks++;
            if (wc != 0 || bc != 0 || el !== 1'b0 || !bo || aa !== 10'h040) begin
                failures++;
                $display("FAIL load_port_%0d got we=%0d be=%0d adel=%b busy_ok=%b a=%h required 0/0/0/1/040",
                         i, wc, bc, el, bo, aa);
            end
        end
    endtask

    task automatic test_errors();
        int lat, wc, bc; logic [9:0] aa; logic [3:0] be; logic [31:0] wd; logic el, es, bo;
        do_access(3'b111, 32'h0, 32'hCAFEF00D, lat, wc, bc, aa, be, wd, el, es, bo);
        checks++;
        if (rdata !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL rdata_hold_store got %h required deadbeef", rdata);
        end
        do_access(3'b100, 32'h102, 32'h0, lat, wc, bc, aa, be, wd, el, es, bo);
        checks++;
        if (lat != 1 || el !== 1'b1 || es !== 1'b0 || wc != 0 || bc != 0) begin
            failures++;
            $display("FAIL lw_misalign got lat=%0d adel=%b ades=%b we=%0d be=%0d required 1/1/0/0/0",
                     lat, el, es, wc, bc);
        end
        checks++;
        if (rdata !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL rdata_hold_err got %h required deadbeef", rdata);
        end
        do_access(3'b110, 32'h101, 32'hFFFF, lat, wc, bc, aa, be, wd, el, es, bo);
        checks++;
        if (lat != 1 || el !== 1'b0 || es !== 1'b1 || wc != 0) begin
            failures++;
            $display("FAIL sh_misalign got lat=%0d adel=%b ades=%b we=%0d required 1/0/1/0", lat, el, es, wc);
        end
        do_access(3'b111, 32'h1000, 32'h55555555, lat, wc, bc, aa, be, wd, el, es, bo);
        checks++;
        if (lat != 1 || es !== 1'b1 || wc != 0 || bc != 0) begin
            failures++;
            $display("FAIL sw_range got lat=%0d ades=%b we=%0d be=%0d required 1/1/0/0", lat, es, wc, bc);
        end
        checks++;
        if (ram[0] !== 32'hCAFEF00D) begin
            failures++;
            $display("FAIL sw_range_ram got %h required cafef00d", ram[0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  ops  [4] = '{3'b111, 3'b100, 3'b011, 3'b101};
        logic [31:0] adrs [4] = '{32'h10, 32'h10, 32'h13, 32'h12};
        logic [31:0] wds  [4] = '{32'h55AA55AA, 32'h0, 32'h0, 32'h77};
        int exp_cyc [4] = '{2, 6, 8, 11};
        int done_cyc [4] = '{-1, -1, -1, -1};
        int idx = 0;
        int idle_cnt = 0;
        logic err_adel = 1'b0;
        logic [31:0] lw_data = '0;
        @(negedge clk);
        req = 1'b1; op = ops[0]; addr = adrs[0]; wdata = wds[0];
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(negedge clk);
            if (!busy) idle_cnt++;
            if (done) begin
                done_cyc[idx] = cyc;
                if (idx == 1) lw_data = rdata;
                if (idx == 2) err_adel = adel;
                idx++;
                if (idx < 4) begin
                    op = ops[idx]; addr = adrs[idx]; wdata = wds[idx];
                end else begin
                    req = 1'b0;
                    break;
                end
            end
        end
        req = 1'b0;
        checks++;
        if (idx != 4) begin
            failures++;
            $display("FAIL b2b_count got %0d dones required 4", idx);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (done_cyc[i] != exp_cyc[i]) begin
                failures++;
                $display("FAIL b2b_done_%0d got cycle %0d required %0d", i, done_cyc[i], exp_cyc[i]);
            end
        end
        checks++;
        if (idle_cnt != 3) begin
            failures++;
            $display("FAIL b2b_idle got %0d idle cycles required 3", idle_cnt);
        end
        checks++;
        if (lw_data !== 32'h55AA55AA || err_adel !== 1'b1) begin
            failures++;
            $display("FAIL b2b_data got lw=%h adel=%b required 55aa55aa/1", lw_data, err_adel);
        end
        checks++;
        if (ram[10'h004] !== 32'h557755AA) begin
            failures++;
            $display("FAIL b2b_ram got %h required 557755aa", ram[10'h004]);
        end
    endtask

    task automatic test_reset_mid();
        int lat, wc, bc; logic [9:0] aa; logic [3:0] be; logic [31:0] wd; logic el, es, bo;
        int spurious = 0;
        do_access(3'b111, 32'h200, 32'h11112222, lat, wc, bc, aa, be, wd, el, es, bo);
        @(negedge clk);
        req = 1'b1; op = 3'b111; addr = 32'h200; wdata = 32'h99999999;
        @(negedge clk);
        checks++;
        if (mem_we !== 1'b1) begin
            failures++;
            $display("FAIL mid_access got mem_we=%b required 1", mem_we);
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if (mem_we !== 1'b0 || busy !== 1'b0 || mem_be !== 4'd0) begin
            failures++;
            $display("FAIL mid_reset got we=%b busy=%b be=%b required 0/0/0", mem_we, busy, mem_be);
        end
        req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (done) spurious++;
        end
        checks++;
        if (spurious != 0 || ram[10'h080] !== 32'h11112222) begin
            failures++;
            $display("FAIL mid_abort got dones=%0d ram=%h required 0/11112222", spurious, ram[10'h080]);
        end
        do_access(3'b100, 32'h200, 32'h0, lat, wc, bc, aa, be, wd, el, es, bo);
        checks++;
        if (rdata !== 32'h11112222 || lat != 3) begin
            failures++;
            $display("FAIL mid_reload got rdata=%h lat=%0d required 11112222/3", rdata, lat);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_store();
        test_load();
        test_errors();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got no completion required finish");
        $fatal(1);
    end

endmodule
